// File: rtl/conv_window_ctrl.sv
// Streaming 3x3 sliding-window scheduler: two pixel-enabled line buffers feed a
// 3x3 register window; each unpadded window is emitted as one registered word.
module conv_window_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       win_valid,
  output logic [9*WIDTH-1:0]         win_data,
  input  logic                       win_ready,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       busy,
  output logic                       done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                col;
  logic [RW-1:0]                row;
  logic [IMG_W-1:0][WIDTH-1:0]  lb1, lb2;
  logic [8:0][WIDTH-1:0]        win_q, win_nxt;
  logic                         accept, last_pix, win_hit;

  assign in_ready = (state == STREAM) && (!win_valid || win_ready);
  assign accept   = in_valid && in_ready;
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
  assign win_hit  = accept && (row >= RW'(2)) && (col >= CW'(2));
  assign busy     = (state == STREAM) || (state == DRAIN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (accept && last_pix) state_nxt = DRAIN;
      DRAIN:   if (win_valid && win_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= last_pix ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Window shifts left one column; new right column is {row-2, row-1, row} at this col
  always_comb begin
    win_nxt = win_q;
    for (int ky = 0; ky < 3; ky++) begin
      win_nxt[ky*3 + 0] = win_q[ky*3 + 1];
      win_nxt[ky*3 + 1] = win_q[ky*3 + 2];
    end
    win_nxt[2] = lb2[IMG_W-1];
    win_nxt[5] = lb1[IMG_W-1];
    win_nxt[8] = in_data;
  end

  // Stage p0: delay lines and window advance only on accepted pixels
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1   <= {lb1[IMG_W-2:0], in_data};
      lb2   <= {lb2[IMG_W-2:0], lb1[IMG_W-1]};
      win_q <= win_nxt;
    end
  end

  // Stage p1: registered window output, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (win_hit) begin
      win_valid <= 1'b1;
      win_data  <= win_nxt;
      win_row   <= row - RW'(2);
      win_col   <= col - CW'(2);
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomized bench for conv_window_ctrl (5x5 frames, int4) against a frame-level
// reference that lists every unpadded 3x3 window straight from the pixel array.
module tb_conv_window_ctrl;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int PW = 4;

  typedef struct {
    logic [9*PW-1:0] d;
    int              r;
    int              c;
  } win_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               in_valid;
  logic [PW-1:0]      in_data;
  logic               in_ready;
  logic               win_valid;
  logic [9*PW-1:0]    win_data;
  logic               win_ready;
  logic [2:0]         win_row;
  logic [2:0]         win_col;
  logic               busy;
  logic               done;

  conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [PW-1:0] frame [W*H];
  win_t          expq[$];
  int            frame_wins = 0;
  int            ready_mode = 0;
  bit            stalled_once = 0;
  int            stall_cnt = 0;
  bit            stall_prev = 0;
  logic [63:0]   held = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Consumer readiness
  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: win_ready = 1'($urandom_range(0, 1));
        2: begin
          if (win_valid && !stalled_once) begin
            win_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 win_ready = 1'b1;
            stalled_once = 1'b1;
          end else begin
            win_ready = 1'b1;
          end
        end
        default: win_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: handshakes against reference queue, stability during stalls
  always @(negedge clk) begin
    if (rst_n) begin
      if (win_valid && win_ready) begin
        if (expq.size() == 0) begin
          chk("extra_win", 1, 0);
        end else begin
          win_t e;
          e = expq.pop_front();
          chk("win_data", win_data, e.d);
          chk("win_row", win_row, e.r);
          chk("win_col", win_col, e.c);
        end
        frame_wins++;
        stall_prev = 1'b0;
      end else if (win_valid) begin
        stall_cnt++;
        chk("stall_in_ready", in_ready, 0);
        if (stall_prev) chk("stall_hold", {win_data, win_row, win_col}, held);
        held = {win_data, win_row, win_col};
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic build_frame(input bit rnd);
    for (int i = 0; i < W*H; i++) frame[i] = rnd ? PW'($urandom) : PW'(i % 16);
  endtask

  task automatic send_frame(input int gap_mode, input int npix, input bit spam);
    int   idx = 0;
    int   cyc = 0;
    bit   acc;
    win_t w;
    for (int r = 0; r <= H-3; r++)
      for (int c = 0; c <= W-3; c++)
        if ((r+2)*W + c + 2 < npix) begin
          w.d = '0;
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              w.d[(ky*3+kx)*PW +: PW] = frame[(r+ky)*W + c + kx];
          w.r = r;
          w.c = c;
          expq.push_back(w);
        end
    frame_wins   = 0;
    stalled_once = 1'b0;
    stall_cnt    = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_start", busy, 1);
    while (idx < npix && cyc < 2000) begin
      case (gap_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? frame[idx] : PW'($urandom);
      start   = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc && idx == 11) chk("pre_win", win_valid, 0);
      if (acc && idx == 12) chk("first_win_lat", win_valid, 1);
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx < npix) chk("feed_timeout", idx, npix);
  endtask

  task automatic wait_done(input int nwin);
    bit seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk("done_busy", busy, 0);
        chk("win_count", frame_wins, nwin);
        chk("queue_empty", expq.size(), 0);
        break;
      end
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      @(negedge clk);
      chk("done_pulse", done, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_win_rc", {win_row, win_col}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pixels offered in IDLE are refused
    in_valid = 1'b1;
    in_data  = 4'hA;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Continuous frame
    ready_mode = 0;
    build_frame(0);
    send_frame(0, W*H, 0);
    wait_done(9);

    // Backpressure on the first window
    ready_mode = 2;
    build_frame(0);
    send_frame(0, W*H, 0);
    wait_done(9);
    chk("stall_cycles", stall_cnt, 4);

    // Source gaps 1,0,0,1
    ready_mode = 0;
    build_frame(0);
    send_frame(1, W*H, 0);
    wait_done(9);

    // Reset mid-frame after 8 accepted pixels
    build_frame(1);
    send_frame(0, 8, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_in_ready", in_ready, 0);
    chk("mid_win_valid", win_valid, 0);
    chk("mid_win_data", win_data, 0);
    chk("mid_win_rc", {win_row, win_col}, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    expq.delete();
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", in_ready, 0);
    in_valid = 1'b0;
    build_frame(0);
    send_frame(0, W*H, 0);
    wait_done(9);

    // start pulses during STREAM, random pixels and random consumer
    ready_mode = 1;
    build_frame(1);
    send_frame(2, W*H, 1);
    wait_done(9);

    // Back-to-back frames, start the cycle after done
    ready_mode = 0;
    build_frame(1);
    send_frame(0, W*H, 0);
    wait_done(9);
    build_frame(1);
    send_frame(0, W*H, 0);
    wait_done(9);

    // Random mix
    for (int f = 0; f < 4; f++) begin
      ready_mode = 1;
      build_frame(1);
      send_frame(2, W*H, 0);
      wait_done(9);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
